// File: rtl/counter_updown_digits.sv
// counter_updown_digits: multi-digit hex/BCD up/down counter with load, wrap/saturate, flags and 7-segment decode
module counter_updown_digits #(
  parameter int DIGITS = 4,
  parameter bit BCD = 1'b0,
  parameter bit WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   hex
);
  localparam logic [3:0] DMAX = BCD ? 4'd9 : 4'd15;
  logic [4*DIGITS-1:0] nxt;
  logic [4*DIGITS-1:0] ld;
  logic [DIGITS:0]     c;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b1100000;
      4'hc: seg = 7'b0110001;
      4'hd: seg = 7'b1000010;
      4'he: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  endfunction
  // c[k] is the carry/borrow into digit k; digit 0 always steps, so tc is the carry out of the top digit
  assign c[0] = 1'b1;
  genvar k;
  for (k = 0; k < DIGITS; k++) begin : g_dig
    logic [3:0] d;
    logic [3:0] l;
    logic       e;
    assign d = q[4*k +: 4];
    assign l = din[4*k +: 4];
    assign e = up ? d == DMAX : d == 4'd0;
    assign c[k+1] = c[k] & e;
    assign nxt[4*k +: 4] = !c[k] ? d : e ? (up ? 4'd0 : DMAX) : up ? d + 4'd1 : d - 4'd1;
    assign ld[4*k +: 4] = BCD && l > 4'd9 ? 4'd9 : l;
    assign hex[7*k +: 7] = seg(d);
  end
  assign tc = c[DIGITS];
  // count register: load beats enable; at a range end either wrap (flagging ovf) or hold
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= ld;
      ovf <= 1'b0;
    end else if (en && !(tc && !WRAP)) begin
      q   <= nxt;
      ovf <= tc;
    end else
      ovf <= 1'b0;
endmodule

// File: tb/tb_counter_updown_digits.sv
// tb_counter_updown_digits: scoreboard bench over hex-wrap, BCD-wrap and hex-saturate instances
module tb_counter_updown_digits;
  logic clk = 1'b0;
  logic aclr, en, up, load;
  logic [15:0] din;
  logic [15:0] q0, q1, q2;
  logic tc0, tc1, tc2, ovf0, ovf1, ovf2;
  logic [27:0] hex0, hex1, hex2;
  int errors = 0;
  int checks = 0;
  event smp;
  typedef struct {
    int          dut;
    string       nm;
    logic [15:0] q;
    logic        tc;
    logic        ovf;
    bit          hc;
    logic [27:0] hex;
  } exp_t;
  exp_t sb[$];
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, S9 = 7'b0000100;
  counter_updown_digits #(.DIGITS(4), .BCD(1'b0), .WRAP(1'b1)) u_hw (
    .clk(clk), .aclr(aclr), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .tc(tc0), .ovf(ovf0), .hex(hex0));
  counter_updown_digits #(.DIGITS(4), .BCD(1'b1), .WRAP(1'b1)) u_bw (
    .clk(clk), .aclr(aclr), .en(en), .up(up), .load(load), .din(din),
    .q(q1), .tc(tc1), .ovf(ovf1), .hex(hex1));
  counter_updown_digits #(.DIGITS(4), .BCD(1'b0), .WRAP(1'b0)) u_hs (
    .clk(clk), .aclr(aclr), .en(en), .up(up), .load(load), .din(din),
    .q(q2), .tc(tc2), .ovf(ovf2), .hex(hex2));
  always #5 clk = ~clk;
  task automatic chk(input int dut, input string nm, input logic [15:0] eq, input logic et,
                     input logic eo, input bit hc = 1'b0, input logic [27:0] eh = '0);
    exp_t x;
    x.dut = dut; x.nm = nm; x.q = eq; x.tc = et; x.ovf = eo; x.hc = hc; x.hex = eh;
    sb.push_back(x);
  endtask
  task automatic step(input logic l, input logic [15:0] d, input logic e, input logic u);
    @(negedge clk);
    load = l; din = d; en = e; up = u;
    @(posedge clk);
  endtask
  // monitor: after each edge (or an explicit mid-cycle sample) pop one expectation and compare
  initial begin
    exp_t x;
    logic [15:0] aq;
    logic at, ao;
    logic [27:0] ah;
    forever begin
      @(posedge clk or smp);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        aq = x.dut == 0 ? q0 : x.dut == 1 ? q1 : q2;
        at = x.dut == 0 ? tc0 : x.dut == 1 ? tc1 : tc2;
        ao = x.dut == 0 ? ovf0 : x.dut == 1 ? ovf1 : ovf2;
        ah = x.dut == 0 ? hex0 : x.dut == 1 ? hex1 : hex2;
        checks++;
        if (aq !== x.q || at !== x.tc || ao !== x.ovf || (x.hc && ah !== x.hex)) begin
          errors++;
          $display("FAIL %s: got q=%h tc=%b ovf=%b hex=%h, expected q=%h tc=%b ovf=%b hex=%h",
                   x.nm, aq, at, ao, ah, x.q, x.tc, x.ovf, x.hc ? x.hex : ah);
        end
      end
    end
  end
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish, %0d expectations pending", sb.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    aclr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
    chk(0, "reset_state", 16'h0000, 1'b0, 1'b0, 1'b1, {4{S0}});
    ->smp;
    step(1, 16'h0120, 0, 1); chk(0, "load_0120", 16'h0120, 1'b0, 1'b0);
    step(0, 16'h0000, 1, 1); chk(0, "cnt_0121", 16'h0121, 1'b0, 1'b0);
    step(0, 16'h0000, 1, 1); chk(0, "cnt_0122", 16'h0122, 1'b0, 1'b0);
    step(0, 16'h0000, 1, 1); chk(0, "cnt_0123", 16'h0123, 1'b0, 1'b0, 1'b1, {S0, S1, S2, S3});
    @(negedge clk);
    en = 1'b0;
    #1 aclr = 1'b1;
    chk(0, "async_clear", 16'h0000, 1'b0, 1'b0, 1'b1, {4{S0}});
    ->smp;
    @(negedge clk);
    aclr = 1'b0;
    step(1, 16'hfffe, 0, 1); chk(0, "hex_load_fffe", 16'hfffe, 1'b0, 1'b0);
    step(0, 16'h0000, 1, 1); chk(0, "hex_ffff_tc", 16'hffff, 1'b1, 1'b0);
    step(0, 16'h0000, 1, 1); chk(0, "hex_wrap_ovf", 16'h0000, 1'b0, 1'b1);
    step(0, 16'h0000, 1, 1); chk(0, "hex_0001_noovf", 16'h0001, 1'b0, 1'b0);
    step(1, 16'h0999, 0, 1); chk(1, "bcd_load_0999", 16'h0999, 1'b0, 1'b0, 1'b1, {S0, S9, S9, S9});
    step(0, 16'h0000, 1, 1); chk(1, "bcd_carry_1000", 16'h1000, 1'b0, 1'b0);
    step(0, 16'h0000, 1, 0); chk(1, "bcd_borrow_0999", 16'h0999, 1'b0, 1'b0, 1'b1, {S0, S9, S9, S9});
    step(1, 16'h0a3f, 0, 0); chk(1, "bcd_clamp", 16'h0939, 1'b0, 1'b0);
    step(1, 16'h0000, 0, 0); chk(1, "bcd_load_0_tc", 16'h0000, 1'b1, 1'b0);
    step(0, 16'h0000, 1, 0); chk(1, "bcd_wrap_down", 16'h9999, 1'b0, 1'b1);
    step(0, 16'h0000, 1, 0); chk(1, "bcd_9998", 16'h9998, 1'b0, 1'b0);
    step(1, 16'hffff, 0, 1); chk(2, "sat_load_ffff", 16'hffff, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h0000, 1, 1); chk(2, $sformatf("sat_hold_max_%0d", i), 16'hffff, 1'b1, 1'b0);
    end
    step(1, 16'h0000, 0, 0); chk(2, "sat_load_0", 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 1, 0); chk(2, $sformatf("sat_hold_min_%0d", i), 16'h0000, 1'b1, 1'b0);
    end
    step(1, 16'h1234, 1, 1); chk(0, "load_over_en", 16'h1234, 1'b0, 1'b0, 1'b1, {S1, S2, S3, S4});
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h0000, 0, 1); chk(0, $sformatf("hold_%0d", i), 16'h1234, 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/counter_updown_digits.md
Name: counter_updown_digits

Overview:
- Parametrised multi-digit up/down counter with per-digit 7-segment decode. Successor to the fixed 16-bit hex up-counter.
- Adds:
  - configurable digit count;
  - hex or BCD radix;
  - count direction;
  - parallel load;
  - wrap or saturate mode;
  - terminal-count and overflow flags.
- Sits between board switches/keys and HEX displays. Also usable as a timebase or event counter elsewhere in the design.

Parameters:
- DIGITS, 4, number of 4-bit digits; counter width = 4*DIGITS.
- BCD, 0: 0 = each digit counts 0..F (radix 16); 1 = each digit counts 0..9 (radix 10).
- WRAP, 1: 1 = wrap at the ends of the range; 0 = saturate at the ends of the range.

Ports:
- clk, input, 1, counting clock, rising edge.
- aclr, input, 1, asynchronous reset, active-high.
- en, input, 1, count enable.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load.
- din, input, 4*DIGITS, load value; digit k = din[4k+3:4k].
- q, output, 4*DIGITS, current count; digit k = q[4k+3:4k].
- tc, output, 1, terminal count (combinational).
- ovf, output, 1, registered wrap pulse.
- hex, output, 7*DIGITS, segment data for digit k at hex[7k+6:7k]; active-low; bit order a..g, MSB = a.

Behaviour:
- Reset:
  - aclr high forces q = 0 and ovf = 0 immediately, independent of clk.
  - Reset held overrides all inputs.
  - Release is synchronous-safe; the first count occurs at the first rising edge after aclr falls.
- Per rising edge, priority order:
  - aclr > load > en.
  - load=1: q <= din, with the BCD clamp below. ovf <= 0. en is ignored.
  - load=0, en=1: count one step in direction up, per the radix rules below.
  - load=0, en=0: q holds; ovf <= 0.
- Radix arithmetic (digit-serial ripple carry/borrow, all within one cycle):
  - Up: digit 0 increments. A digit at its max (F, or 9 if BCD) goes to 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 goes to its max and borrows from the next digit.
- BCD load clamp: when BCD=1, any loaded digit > 9 is stored as 9. No clamp when BCD=0.
- Range:
  - MAXV = all digits at max (0xFFFF for hex, 9999 for BCD with DIGITS=4).
  - MINV = 0.
- tc:
  - 1 when (up=1 and q=MAXV) or (up=0 and q=0).
  - Purely combinational; independent of en.
- Boundary behaviour, en=1 and tc=1:
  - WRAP=1:
    - up: q <= 0.
    - down: q <= MAXV.
    - ovf <= 1 for exactly one cycle, the cycle in which q shows the wrapped value.
  - WRAP=0: q holds at MAXV or 0; ovf <= 0.
- ovf is otherwise 0 after every edge where no wrap occurred.
- Direction change takes effect on the same edge. tc recomputes immediately from the new up value.
- Digit decode:
  - Each digit is decoded combinationally from q. Latency 0 relative to q.
  - Patterns (abcdefg, 0 = lit):
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110
    - 4=1001100, 5=0100100, 6=0100000, 7=0001111
    - 8=0000000, 9=0000100, A=0001000, b=1100000
    - C=0110001, d=1000010, E=0110000, F=0111000
  - No blank state is reachable in BCD mode, because q digits never exceed 9.

Test Plan:
- Reset:
  - Stimulus: DIGITS=4, BCD=0. Count to 0x0123, then assert aclr mid-cycle.
  - Required: q = 0x0000 before the next edge; ovf = 0; hex = four copies of 0000001.
- Hex wrap up:
  - Stimulus: load 0xFFFE, en=1, up=1, 3 edges.
  - Required: q = 0xFFFF (tc=1), then 0x0000 with ovf=1 for one cycle, then 0x0001 with ovf=0.
- BCD carry and borrow:
  - Stimulus: BCD=1. Load 0x0999, en=1, up=1, one edge; then up=0, one edge.
  - Required: q = 0x1000, then 0x0999. hex digit 0 shows 0000100 (9).
- BCD clamp and wrap down:
  - Stimulus: BCD=1. Load din=0x0A3F; observe; then load 0x0000 and apply one down edge.
  - Required: after load, q = 0x0939. After the down edge, q = 0x9999 and ovf=1.
- Saturate:
  - Stimulus: WRAP=0. Load 0xFFFF, en=1, up=1, 5 edges; then up=0 from q=0x0000, 3 edges.
  - Required: q stays 0xFFFF, then stays 0x0000; ovf never asserts; tc=1 throughout.
- Priority and hold:
  - Stimulus: load=1 and en=1 together with din=0x1234.
  - Required: q = 0x1234 (no increment).
  - Stimulus: en=0 for 4 edges.
  - Required: q unchanged.
